// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 1-D convolution frame sequencer and its
// integration wrapper.
//   seq_state_t    : sequencer FSM states
//   DEFAULT_DATA_W : default sample / result width
//   num_out()      : number of valid convolution results per frame
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN
    } seq_state_t;

    localparam int DEFAULT_DATA_W = 32;

    // A "valid" 1-D convolution of frame_len samples with taps weights.
    function automatic int num_out(input int frame_len, input int taps);
        return frame_len - taps + 1;
    endfunction

endpackage

// File: rtl/conv_frame_sequencer.sv
// ---------------------------------------------------------------------------
// conv_frame_sequencer
// Frame-level controller for the systolic 1-D convolution array.
// Collects FRAME_LEN samples, clears the array, streams the samples in one
// per cycle followed by zero-flush cycles, captures the NUM_OUT results at
// fixed pipeline offsets and replays them on a valid/ready output stream.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_ready   input sample handshake, s_data sample
//   arr_clr           one-cycle array clear (wrapper ORs it into array rst)
//   arr_x, arr_y      array x_in / y_in (arr_y is always 0)
//   arr_y_out         array y_out
//   m_valid/m_ready   result handshake, m_data result, m_last final result
//   busy              high whenever not IDLE
//   frame_done        one-cycle pulse after the last result handshake
// ---------------------------------------------------------------------------
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int FRAME_LEN = 5,
    parameter int NUM_TAPS  = 3,
    parameter int OUT_LAT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              arr_clr,
    output logic [DATA_W-1:0] arr_x,
    output logic [DATA_W-1:0] arr_y,
    input  logic [DATA_W-1:0] arr_y_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              frame_done
);

    localparam int NUM_OUT  = num_out(FRAME_LEN, NUM_TAPS);
    localparam int CYC_LAST = OUT_LAT + NUM_OUT - 1;

    // Counter widths cover exactly the range used inside one frame.
    localparam int WR_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN)  : 1;
    localparam int CYC_W = (CYC_LAST > 0)  ? $clog2(CYC_LAST+1) : 1;
    localparam int RD_W  = (NUM_OUT > 1)   ? $clog2(NUM_OUT)    : 1;

    localparam logic [WR_W-1:0]  WR_LAST    = WR_W'(FRAME_LEN - 1);
    localparam logic [CYC_W-1:0] FEED_LAST  = CYC_W'(FRAME_LEN - 1);
    localparam logic [CYC_W-1:0] CAP_FIRST  = CYC_W'(OUT_LAT);
    localparam logic [CYC_W-1:0] CAP_LAST   = CYC_W'(CYC_LAST);
    localparam logic [RD_W-1:0]  RD_LAST    = RD_W'(NUM_OUT - 1);
    // When the last result lands on the last feed cycle there is nothing
    // left to flush and FEED hands straight over to DRAIN.
    localparam bit               HAS_FLUSH  = (CYC_LAST > FRAME_LEN - 1);

    generate
        if (FRAME_LEN < NUM_TAPS || CYC_LAST < FRAME_LEN - 1 || NUM_TAPS < 1
            || OUT_LAT < 0) begin : g_bad_params
            $error("conv_frame_sequencer: illegal FRAME_LEN/NUM_TAPS/OUT_LAT");
        end
    endgenerate

    seq_state_t         state_reg, state_next;
    logic [WR_W-1:0]    wr_reg,    wr_next;
    logic [CYC_W-1:0]   cyc_reg,   cyc_next;
    logic [RD_W-1:0]    rd_reg,    rd_next;
    logic               frame_done_reg, frame_done_next;

    logic [DATA_W-1:0]  ibuf [FRAME_LEN];
    logic [DATA_W-1:0]  obuf [NUM_OUT];

    logic               s_accept;
    logic               m_accept;
    logic               cap_en;
    logic [CYC_W-1:0]   cap_off;

    // ------------------------------------------------------------------
    // Output decode (state/counters only; rst gates s_ready so no sample
    // is taken while reset is asserted)
    // ------------------------------------------------------------------
    assign s_ready    = !rst && (state_reg == IDLE || state_reg == LOAD);
    assign arr_clr    = (state_reg == CLEAR);
    assign arr_x      = (state_reg == FEED) ? ibuf[WR_W'(cyc_reg)] : '0;
    assign arr_y      = '0;
    assign m_valid    = (state_reg == DRAIN);
    assign m_data     = (state_reg == DRAIN) ? obuf[rd_reg] : '0;
    assign m_last     = (state_reg == DRAIN) && (rd_reg == RD_LAST);
    assign busy       = (state_reg != IDLE);
    assign frame_done = frame_done_reg;

    assign s_accept = s_valid && s_ready;
    assign m_accept = m_valid && m_ready;

    // Result j appears on y_out during cycle OUT_LAT+j of FEED/FLUSH.
    assign cap_off = cyc_reg - CAP_FIRST;
    assign cap_en  = (state_reg == FEED || state_reg == FLUSH)
                     && (cyc_reg >= CAP_FIRST) && (cyc_reg <= CAP_LAST);

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            wr_reg         <= '0;
            cyc_reg        <= '0;
            rd_reg         <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wr_reg         <= wr_next;
            cyc_reg        <= cyc_next;
            rd_reg         <= rd_next;
            frame_done_reg <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wr_next         = wr_reg;
        cyc_next        = cyc_reg;
        rd_next         = rd_reg;
        frame_done_next = 1'b0;

        case (state_reg)
            IDLE, LOAD: begin
                if (s_accept) begin
                    if (wr_reg == WR_LAST) begin
                        state_next = CLEAR;
                        wr_next    = '0;
                    end else begin
                        state_next = LOAD;
                        wr_next    = wr_reg + WR_W'(1);
                    end
                end
            end
            CLEAR: begin
                cyc_next   = '0;
                state_next = FEED;
            end
            FEED: begin
                if (cyc_reg == FEED_LAST) begin
                    if (HAS_FLUSH) begin
                        state_next = FLUSH;
                        cyc_next   = cyc_reg + CYC_W'(1);
                    end else begin
                        state_next = DRAIN;
                    end
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end
            FLUSH: begin
                // Hold cyc on exit so it never wraps past its range.
                if (cyc_reg == CAP_LAST) begin
                    state_next = DRAIN;
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end
            DRAIN: begin
                if (m_accept) begin
                    if (rd_reg == RD_LAST) begin
                        state_next      = IDLE;
                        rd_next         = '0;
                        frame_done_next = 1'b1;
                    end else begin
                        rd_next = rd_reg + RD_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sample and result buffers (contents are not reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (s_accept) begin
            ibuf[wr_reg] <= s_data;
        end
        if (cap_en) begin
            obuf[RD_W'(cap_off)] <= arr_y_out;
        end
    end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_conv_frame_sequencer
// Scoreboard bench for conv_frame_sequencer. A behavioural array stub with
// weights (1,2,3) produces y_j at FEED cycle OUT_LAT+j (garbage elsewhere).
// Each fully sent frame pushes its expected results; a negedge monitor pops
// and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_conv_frame_sequencer;

    localparam int DW = 32;
    localparam int FL = 5;
    localparam int NT = 3;
    localparam int OL = 4;
    localparam int NO = FL - NT + 1;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          arr_clr;
    logic [DW-1:0] arr_x;
    logic [DW-1:0] arr_y;
    logic [DW-1:0] arr_y_out;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          frame_done;

    conv_frame_sequencer #(
        .DATA_W    (DW),
        .FRAME_LEN (FL),
        .NUM_TAPS  (NT),
        .OUT_LAT   (OL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .arr_clr    (arr_clr),
        .arr_x      (arr_x),
        .arr_y      (arr_y),
        .arr_y_out  (arr_y_out),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural array stub
    // ------------------------------------------------------------------
    logic [DW-1:0] hist [16];
    int            stub_cnt = 0;
    int            stub_j;
    logic [DW-1:0] stub_sum;

    always @(posedge clk) begin
        if (rst || arr_clr) begin
            stub_cnt <= 0;
        end else begin
            if (stub_cnt < 16) hist[stub_cnt] <= arr_x;
            if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
        end
    end

    always_comb begin
        stub_j    = stub_cnt - OL;
        stub_sum  = arr_y;
        arr_y_out = 32'hBAD0_0000 ^ DW'(stub_cnt);
        if (stub_j >= 0 && stub_j < NO) begin
            for (int k = 0; k < NT; k++) begin
                if (stub_j + k == stub_cnt)
                    stub_sum = stub_sum + DW'(k + 1) * arr_x;
                else
                    stub_sum = stub_sum + DW'(k + 1) * hist[(stub_j + k) % 16];
            end
            arr_y_out = stub_sum;
        end
    end

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          exp_q [$];
    logic [DW-1:0] frame_buf [FL];

    task automatic push_expected();
        exp_t e;
        for (int j = 0; j < NO; j++) begin
            e.data = '0;
            for (int k = 0; k < NT; k++)
                e.data = e.data + DW'(k + 1) * frame_buf[j + k];
            e.last = (j == NO - 1);
            exp_q.push_back(e);
        end
    endtask

    // ------------------------------------------------------------------
    // Result consumer: 0 = always ready, 1 = random, 2 = 3-cycle stall
    // ------------------------------------------------------------------
    int m_mode = 0;
    int bp_cnt = 0;

    initial m_ready = 1'b1;
    always @(posedge clk) begin
        #2;
        case (m_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: begin
                if (m_valid) begin
                    if (bp_cnt < 3) begin
                        m_ready = 1'b0;
                        bp_cnt++;
                    end else begin
                        m_ready = 1'b1;
                        bp_cnt  = 0;
                    end
                end else begin
                    m_ready = 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic          fd_exp     = 1'b0;
    logic          hold_valid = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    logic          clr_wait   = 1'b0;
    int            since_clr  = 0;
    int            res_idx    = 0;

    always @(negedge clk) begin
        if (rst) begin
            fd_exp     = 1'b0;
            hold_valid = 1'b0;
            clr_wait   = 1'b0;
        end else begin
            check("frame_done", DW'(frame_done), DW'(fd_exp));
            fd_exp = 1'b0;
            if (arr_clr) begin
                clr_wait  = 1'b1;
                since_clr = 0;
                check("arr_y", arr_y, '0);
            end else begin
                since_clr++;
            end
            if (m_valid) begin
                if (clr_wait) begin
                    check("m_valid latency", DW'(since_clr), DW'(OL + NO + 1));
                    clr_wait = 1'b0;
                end
                check("s_ready in drain", DW'(s_ready), '0);
                if (hold_valid) begin
                    check("m_data hold", m_data, hold_data);
                    check("m_last hold", DW'(m_last), DW'(hold_last));
                end
                if (m_ready) begin
                    hold_valid = 1'b0;
                    check("result queued", DW'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        $display("result %0d: data=%0d last=%0b (want %0d/%0b)",
                                 res_idx, m_data, m_last, e.data, e.last);
                        res_idx++;
                        check("m_data", m_data, e.data);
                        check("m_last", DW'(m_last), DW'(e.last));
                    end
                    if (m_last) fd_exp = 1'b1;
                end else begin
                    hold_valid = 1'b1;
                    hold_data  = m_data;
                    hold_last  = m_last;
                end
            end else if (hold_valid) begin
                check("m_valid held", DW'(m_valid), 1);
                hold_valid = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // gap_mode: 0 = back-to-back, 1 = alternate valid/idle, 2 = random gaps.
    // Returns one cycle into FEED (cyc 0) after checking the clear pulse.
    task automatic send_frame(input int gap_mode);
        for (int i = 0; i < FL; i++) begin
            int gaps;
            int n;
            gaps = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
            repeat (gaps) @(negedge clk);
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = frame_buf[i];
            n = 0;
            while (!s_ready && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) begin
                check("s_ready timeout", DW'(s_ready), 1);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_data  = $urandom;
        end
        push_expected();
        $display("frame sent: %0d %0d %0d %0d %0d", frame_buf[0], frame_buf[1],
                 frame_buf[2], frame_buf[3], frame_buf[4]);
        check("arr_clr after last accept", DW'(arr_clr), 1);
        check("s_ready in clear", DW'(s_ready), '0);
        check("arr_x in clear", arr_x, '0);
        @(posedge clk);
        #1;
        check("first arr_x", arr_x, frame_buf[0]);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() > 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain timeout", DW'(n < 2000), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < FL; i++) frame_buf[i] = DW'(i + 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s_ready"},    DW'(s_ready),    '0);
        check({tag, " busy"},       DW'(busy),       '0);
        check({tag, " arr_clr"},    DW'(arr_clr),    '0);
        check({tag, " arr_x"},      arr_x,           '0);
        check({tag, " m_valid"},    DW'(m_valid),    '0);
        check({tag, " m_data"},     m_data,          '0);
        check({tag, " m_last"},     DW'(m_last),     '0);
        check({tag, " frame_done"}, DW'(frame_done), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("s_ready after reset", DW'(s_ready), 1);
        check("busy after reset", DW'(busy), '0);

        // Basic frame 1..5
        set_ramp();
        send_frame(0);
        wait_drain();

        // Gapped input
        set_ramp();
        send_frame(1);
        wait_drain();

        // Back-pressure: 3 stall cycles per result
        m_mode = 2;
        set_ramp();
        send_frame(0);
        wait_drain();
        m_mode = 0;

        // Back-to-back frames
        set_ramp();
        send_frame(0);
        for (int i = 0; i < FL; i++) frame_buf[i] = 32'd2;
        send_frame(0);
        wait_drain();

        // Reset in FEED at cyc 2
        set_ramp();
        send_frame(0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("arr_x at cyc 2", arr_x, frame_buf[2]);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset_outputs("mid-feed reset");
        rst = 1'b0;
        @(negedge clk);
        check("s_ready after mid-feed reset", DW'(s_ready), 1);

        // Fresh frame after reset
        set_ramp();
        send_frame(0);
        wait_drain();

        // Randomised frames, gaps and consumer behaviour
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < FL; i++) frame_buf[i] = $urandom;
            m_mode = $urandom_range(0, 2);
            send_frame(2);
            if ($urandom_range(0, 1) == 1) wait_drain();
        end
        wait_drain();
        m_mode = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level controller for the B1 1-D convolution systolic array (`b1_systolic_array`). It collects a fixed-length frame of input samples over a valid/ready stream and clears the array. It then feeds the samples to the array one per cycle, followed by zero-flush cycles. It captures the valid `y_out` results at fixed pipeline offsets and replays them on a valid/ready output stream, sitting between the sample source and the result consumer.

## Interface
Parameters:
- `DATA_W`, 32, width of samples, `x_in`, `y_in` and `y_out`
- `FRAME_LEN`, 5, number of samples per frame
- `NUM_TAPS`, 3, number of array taps
- `OUT_LAT`, 4, FEED-cycle index (0-based) at which array result 0 is sampled
- Derived: `NUM_OUT = FRAME_LEN-NUM_TAPS+1`
- Elaboration error unless `FRAME_LEN >= NUM_TAPS` and `OUT_LAT+NUM_OUT-1 >= FRAME_LEN-1`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  sequencer can accept a sample
- `s_data`  in  DATA_W  input sample
- `arr_clr`  out  1  one-cycle array clear; top level drives the array `rst` with `rst | arr_clr`
- `arr_x`  out  DATA_W  to array `x_in`
- `arr_y`  out  DATA_W  to array `y_in`; constant 0
- `arr_y_out`  in  DATA_W  from array `y_out`
- `m_valid`  out  1  result valid
- `m_ready`  in  1  consumer accepts the result
- `m_data`  out  DATA_W  result
- `m_last`  out  1  marks the final result of the frame
- `busy`  out  1  high in every state except IDLE
- `frame_done`  out  1  one-cycle pulse after the last result handshake

## Operation
- States: IDLE → LOAD → CLEAR → FEED → FLUSH → DRAIN → IDLE.
- **IDLE / LOAD:**
  - `s_ready=1`.
  - Each `s_valid&&s_ready` writes `s_data` to `ibuf[wr]` and increments `wr`.
  - The first accept moves IDLE→LOAD.
  - The accept with `wr==FRAME_LEN-1` moves to CLEAR and resets `wr` to 0.
- **CLEAR:**
  - Lasts one cycle.
  - `arr_clr=1`, `arr_x=0`, `s_ready=0`.
  - Resets `cyc` to 0.
- **FEED:**
  - Lasts `FRAME_LEN` cycles.
  - `arr_x=ibuf[cyc]`, and `cyc` increments each cycle.
  - Moves to FLUSH after `cyc==FRAME_LEN-1`.
- **FLUSH:**
  - `arr_x=0`, and `cyc` keeps counting.
  - Moves to DRAIN after `cyc==OUT_LAT+NUM_OUT-1`.
- **Capture (FEED and FLUSH):**
  - When `OUT_LAT <= cyc <= OUT_LAT+NUM_OUT-1`, write `obuf[cyc-OUT_LAT] <= arr_y_out` at the edge ending that cycle.
  - The array has no stall, so capture is never skipped.
- **DRAIN:**
  - `m_valid=1`, `m_data=obuf[rd]`, `m_last=(rd==NUM_OUT-1)`.
  - `rd` advances on each `m_valid&&m_ready`.
  - On the last handshake: go to IDLE, pulse `frame_done`, reset `rd`.
- `arr_y` is always 0. Arithmetic is done entirely in the array; the sequencer only moves data.
- Counter widths: `wr`, `cyc` and `rd` are each `$clog2(max range + 1)` wide, with no wrap-around inside a frame.

## Timing
- **Reset values:**
  - state=IDLE, `wr`=`cyc`=`rd`=0.
  - `s_ready=0` during the reset cycle and 1 in the first cycle after reset.
  - `arr_clr=0`, `arr_x=0`, `m_valid=0`, `m_data=0`, `m_last=0`, `busy=0`, `frame_done=0`.
  - `ibuf`/`obuf` contents are not reset.
- **Reset mid-operation** in any state returns to IDLE the next cycle. Partial frames and captured results are discarded, and no `frame_done` is issued.
- **Latency:**
  - Last sample accept to `arr_clr`: 1 cycle.
  - First `arr_x` sample: 2 cycles after the last accept.
  - First `m_valid`: `OUT_LAT+NUM_OUT+1` cycles after CLEAR.
- `s_ready=0` from CLEAR through DRAIN. A new frame's first sample can be accepted in the cycle after `frame_done`.
- `m_data` and `m_last` hold stable while `m_valid&&!m_ready`. Back-pressure is unlimited.
- Outputs are registered or decoded from state/counters only; there are no combinational paths from `s_valid` or `m_ready` to outputs.

## Structure
- Shared package `conv_pkg`:
  - state enum `seq_state_t` (IDLE, LOAD, CLEAR, FEED, FLUSH, DRAIN)
  - default `DATA_W`
  - function `num_out(frame_len, taps)`
- No sub-module is required; `ibuf` and `obuf` are small register arrays.
- The integration wrapper `conv_frame_top` instantiates this block and `b1_systolic_array`.

## Test plan
All tests use a behavioural array stub with weights (1,2,3) that produces `y_j=Σw_k·x_{j+k}` at FEED cycle `OUT_LAT+j`.
- **Basic frame:** send x=1..5 with `m_ready=1` → `arr_clr` pulses once; `arr_x` = 1,2,3,4,5,0,0; outputs 14, 20, 26 with `m_last` on 26; `frame_done` one cycle after 26.
- **Gapped input:** `s_valid` toggles 1/0 for samples 1..5 → same arr_x order and same outputs 14, 20, 26.
- **Back-pressure:** `m_ready` low for 3 cycles at each result → `m_data` holds 14, then 20, then 26; `s_ready` stays 0 until after `frame_done`.
- **Back-to-back frames:** frame 1..5, then 2,2,2,2,2 → 14, 20, 26, then 12, 12, 12; `arr_clr` pulses before each FEED.
- **Reset mid-FEED:** assert `rst` at `cyc`=2 → next cycle IDLE with all outputs at reset values; a fresh 1..5 frame afterwards yields 14, 20, 26.
- **Parameter sweep:** `FRAME_LEN`=8, `NUM_TAPS`=3, `OUT_LAT`=4, input 1..8 → 6 outputs 14, 20, 26, 32, 38, 44.
